// File: rtl/conv_encoder_tx.sv
// -----------------------------------------------------------------------------
// conv_encoder_tx
// Rate-1/2, constraint-length-3 convolutional encoder with a word-wide
// valid/ready stream interface. Each accepted 8-bit word is encoded in one
// cycle, MSB first, into a 16-bit coded word. After the last word of a frame
// a tail word is emitted. The tail is the encoding of 8'h00, and it flushes
// the trellis back to the all-zero state.
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous, active-low reset
//   data_in      : information bits, data_in[7] is first in time
//   in_valid     : data_in / in_last valid
//   in_last      : data_in is the last word of the frame
//   in_ready     : encoder accepts a word this cycle
//   data_enc     : coded word, c0 of bit t on [15-2t], c1 on [14-2t]
//   out_valid    : data_enc holds a valid coded word
//   out_last     : data_enc is the tail (flush) word
//   out_ready    : downstream accepts data_enc this cycle
//   frame_words  : data words accepted in the current frame (wraps at 256)
// -----------------------------------------------------------------------------
module conv_encoder_tx #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [15:0] data_enc,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  frame_words
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TAIL = 1'b1
  } state_e;

  // Even parity of a 3-bit tap vector.
  function automatic logic parity3(input logic [2:0] v);
    return ^v;
  endfunction

  // Encode one word MSB first from trellis state {s1,s2}.
  // Returns {coded_word[15:0], next_state[1:0]}.
  function automatic logic [17:0] encode_word(input logic [7:0] word,
                                              input logic [1:0] state_in);
    logic [7:0]  w;
    logic [1:0]  s;
    logic [15:0] code;
    logic [2:0]  taps;
    w    = word;
    s    = state_in;
    code = 16'h0000;
    for (int unsigned t = 32'd0; t < 32'd8; t++) begin
      taps = {w[7], s};
      // Shifting left puts bit t's pair on [15-2t] and [14-2t].
      code = {code[13:0], parity3(taps & G0), parity3(taps & G1)};
      s    = {w[7], s[1]};
      w    = {w[6:0], 1'b0};
    end
    return {code, s};
  endfunction

  state_e      state_q, state_d;
  logic [1:0]  trellis_q, trellis_d;
  logic [15:0] data_enc_q, data_enc_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [7:0]  frame_words_q, frame_words_d;

  logic        out_free_s;
  logic        in_fire_s;
  logic [7:0]  enc_src_s;
  logic [15:0] enc_word_s;
  logic [1:0]  enc_state_s;

  // The output register can take a new word if it is empty or is being drained.
  assign out_free_s = !out_valid_q || out_ready;
  // The rst term keeps in_ready low while reset is held.
  assign in_ready   = rst && (state_q == ST_RUN) && out_free_s;
  assign in_fire_s  = in_valid && in_ready;

  // One shared encoder. In TAIL it encodes zeros to flush the trellis.
  assign enc_src_s  = (state_q == ST_TAIL) ? 8'h00 : data_in;
  assign {enc_word_s, enc_state_s} = encode_word(enc_src_s, trellis_q);

  assign data_enc    = data_enc_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign frame_words = frame_words_q;

  // Next-state logic for the RUN/TAIL controller and its registered outputs.
  always_comb begin
    state_d       = state_q;
    trellis_d     = trellis_q;
    data_enc_d    = data_enc_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    frame_words_d = frame_words_q;
    case (state_q)
      ST_RUN: begin
        if (in_fire_s) begin
          data_enc_d    = enc_word_s;
          out_valid_d   = 1'b1;
          out_last_d    = 1'b0;
          trellis_d     = enc_state_s;
          frame_words_d = frame_words_q + 8'd1;
          if (in_last) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_RUN;
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      ST_TAIL: begin
        if (out_free_s) begin
          data_enc_d    = enc_word_s;
          out_valid_d   = 1'b1;
          out_last_d    = 1'b1;
          trellis_d     = 2'b00;
          frame_words_d = 8'd0;
          state_d       = ST_RUN;
        end else begin
          state_d = ST_TAIL;
        end
      end
      default: begin
        state_d       = ST_RUN;
        trellis_d     = 2'b00;
        out_valid_d   = 1'b0;
        out_last_d    = 1'b0;
        frame_words_d = 8'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      trellis_q     <= 2'b00;
      data_enc_q    <= 16'h0000;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_words_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      trellis_q     <= trellis_d;
      data_enc_q    <= data_enc_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_words_q <= frame_words_d;
    end
  end

endmodule
